uart_parity_engine: RTL and testbench

- Bit-serial parity engine for the UART datapath. Replaces the fixed 5–8-bit combinational parity with a parametrised sequential block.
- Accumulates parity LSB-first as each data bit is shifted on the line. One block serves both the TX framer (generate) and the RX deframer (check).
- Supports none/even/odd/mark/space parity and a runtime-selectable data length.

---
 rtl/uart_parity_engine.sv | 130 +++++++++++++
 tb/tb_uart_parity_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_engine.sv
// Bit-serial UART parity engine: accumulates parity LSB-first, generates (TX) or checks (RX).
// Optional saturating parity-error counter enabled by defining UART_PARITY_ERR_CNT_EN.
module uart_parity_engine #(
  parameter int MIN_DATA_BITS = 5,
  parameter int MAX_DATA_BITS = 9,
  parameter int CFG_W         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             check_mode,
  input  logic [2:0]       parity_mode,
  input  logic [CFG_W-1:0] num_data,
  input  logic             bit_valid,
  input  logic             bit_in,
`ifdef UART_PARITY_ERR_CNT_EN
  input  logic             err_count_clr,
  output logic [7:0]       err_count,
`endif
  output logic             busy,
  output logic             done,
  output logic             parity_bit,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(MAX_DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, DONE} state_t;

  state_t           state, state_next;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             check_lat;
  logic [2:0]       mode_lat;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CFG_W-1:0] nd);
    int n;
    n = MIN_DATA_BITS + int'(nd);
    if (n > MAX_DATA_BITS) n = MAX_DATA_BITS;
    return CNT_W'(n);
  endfunction

  // Modes 5-7 behave as "none".
  function automatic logic parity_active(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd4);
  endfunction

  function automatic logic parity_value(input logic [2:0] mode, input logic a);
    case (mode)
      3'd1:    return a;
      3'd2:    return ~a;
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic acc_next;
  logic last_bit;
  logic to_check;

  assign acc_next = acc ^ bit_in;
  assign last_bit = (cnt == len - 1'b1);
  assign to_check = check_lat && parity_active(mode_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // start overrides everything, including a same-cycle bit_valid.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ACCUM;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ACCUM:   if (bit_valid && last_bit) state_next = to_check ? CHECK : DONE;
        CHECK:   if (bit_valid) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 1'b0;
      cnt        <= '0;
      len        <= '0;
      check_lat  <= 1'b0;
      mode_lat   <= 3'd0;
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
    end else if (start) begin
      acc        <= 1'b0;
      cnt        <= '0;
      len        <= clamp_len(num_data);
      check_lat  <= check_mode;
      mode_lat   <= parity_mode;
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
    end else if (bit_valid) begin
      if (state == ACCUM) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (last_bit && !to_check) begin
          parity_bit <= parity_value(mode_lat, acc_next);
          parity_err <= 1'b0;
        end
      end else if (state == CHECK) begin
        parity_bit <= parity_value(mode_lat, acc);
        parity_err <= (bit_in != parity_value(mode_lat, acc));
      end
    end
  end

  assign busy = (state == ACCUM) || (state == CHECK);
  assign done = (state == DONE);

`ifdef UART_PARITY_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         err_count <= 8'd0;
    else if (err_count_clr)                             err_count <= 8'd0;
    else if (done && parity_err && err_count != 8'hFF)  err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: stimulus pushes expected results, a monitor checks each done.
module tb_uart_parity_engine;
  localparam int MIN_B = 5;
  localparam int MAX_B = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       check_mode = 1'b0;
  logic [2:0] parity_mode = 3'd0;
  logic [1:0] num_data = 2'd0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       busy, done, parity_bit, parity_err;
`ifdef UART_PARITY_ERR_CNT_EN
  logic       err_count_clr = 1'b0;
  logic [7:0] err_count;
`endif

  uart_parity_engine #(.MIN_DATA_BITS(MIN_B), .MAX_DATA_BITS(MAX_B), .CFG_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .check_mode(check_mode),
    .parity_mode(parity_mode), .num_data(num_data), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef UART_PARITY_ERR_CNT_EN
    .err_count_clr(err_count_clr), .err_count(err_count),
`endif
    .busy(busy), .done(done), .parity_bit(parity_bit), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic pb;
    logic pe;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("done_without_expectation", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("parity_bit", parity_bit, e.pb);
        chk("parity_err", parity_err, e.pe);
      end
    end
  end

  // Reference: parity from the popcount of the first N data bits.
  task automatic model(input logic chkm, input logic [2:0] mode, input logic [1:0] nd,
                       input logic [8:0] data, input logic pbit,
                       output logic pb, output logic pe, output logic consumes, output int n);
    int ones;
    logic active;
    n = MIN_B + int'(nd);
    if (n > MAX_B) n = MAX_B;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(data[i]);
    active = (mode >= 3'd1) && (mode <= 3'd4);
    case (mode)
      3'd1:    pb = (ones % 2) == 1;
      3'd2:    pb = (ones % 2) == 0;
      3'd3:    pb = 1'b1;
      default: pb = 1'b0;
    endcase
    consumes = chkm && active;
    pe = consumes && (pbit != pb);
  endtask

  task automatic issue_start(input logic chkm, input logic [2:0] mode, input logic [1:0] nd);
    start = 1'b1; check_mode = chkm; parity_mode = mode; num_data = nd;
    @(posedge clk); #1;
    start = 1'b0; check_mode = $urandom_range(0, 1); parity_mode = 3'($urandom_range(0, 7));
    num_data = 2'($urandom_range(0, 3));
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      bit_valid = 1'b0; bit_in = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    bit_valid = 1'b1; bit_in = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  // Leaves the bench in the DONE cycle of the frame with the expectation queued.
  task automatic frame_to_done(input logic chkm, input logic [2:0] mode, input logic [1:0] nd,
                               input logic [8:0] data, input logic pbit, input int maxgap);
    logic pb, pe, cons;
    int n;
    model(chkm, mode, nd, data, pbit, pb, pe, cons, n);
    issue_start(chkm, mode, nd);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) send_bit(data[i], $urandom_range(0, maxgap));
    if (cons) send_bit(pbit, $urandom_range(0, maxgap));
    sb.push_back('{cyc, pb, pe});
  endtask

  task automatic frame(input logic chkm, input logic [2:0] mode, input logic [1:0] nd,
                       input logic [8:0] data, input logic pbit, input int maxgap);
    frame_to_done(chkm, mode, nd, data, pbit, maxgap);
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_parity_bit", parity_bit, 0);
    chk("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Stray bit in IDLE must be ignored.
    send_bit(1'b1, 0);

    frame(0, 3'd1, 2'd3, 9'h0A7, 1'b0, 0);
    frame(0, 3'd2, 2'd0, 9'h015, 1'b0, 1);
    frame(0, 3'd2, 2'd0, 9'h003, 1'b0, 0);
    frame(1, 3'd1, 2'd3, 9'h00F, 1'b1, 0);
    frame(1, 3'd1, 2'd3, 9'h00F, 1'b0, 2);
    frame(1, 3'd3, 2'd2, 9'h055, 1'b0, 0);
    frame(1, 3'd4, 2'd2, 9'h055, 1'b0, 0);
    frame(1, 3'd0, 2'd1, 9'h03F, 1'b1, 0);
    frame(1, 3'd6, 2'd0, 9'h01F, 1'b1, 1);

    // Abort: the first frame must produce no done.
    issue_start(0, 3'd1, 2'd3);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    frame(0, 3'd2, 2'd0, 9'h000, 1'b0, 0);

    // Start coincident with a valid 1 bit: that bit must not be counted.
    bit_valid = 1'b1; bit_in = 1'b1;
    issue_start(0, 3'd1, 2'd0);
    chk("coincident_busy", busy, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
    sb.push_back('{cyc, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Reset mid-ACCUM.
    issue_start(0, 3'd1, 2'd3);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    rst_n = 1'b0; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_parity_bit", parity_bit, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while the done pulse is showing: no done, results cleared.
    issue_start(0, 3'd3, 2'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
    rst_n = 1'b0; #1;
    chk("donerst_done", done, 0);
    chk("donerst_parity_bit", parity_bit, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef UART_PARITY_ERR_CNT_EN
    chk("errcnt_after_reset", err_count, 0);
    for (int k = 0; k < 3; k++) frame(1, 3'd1, 2'd3, 9'h00F, 1'b1, 0);
    chk("errcnt_three", err_count, 3);
    frame_to_done(1, 3'd1, 2'd3, 9'h00F, 1'b1, 0);
    err_count_clr = 1'b1;
    @(posedge clk); #1;
    err_count_clr = 1'b0;
    chk("errcnt_clr_priority", err_count, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      frame($urandom_range(0, 1), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            9'($urandom), 1'($urandom_range(0, 1)), 2);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
